// File: rtl/vproc_vreg_wr_arbiter.sv
// Vector register file write-port arbiter.
// Round-robin with per-requester burst lock and optional output register.
module vproc_vreg_wr_arbiter #(
  parameter int REQ_CNT = 5,
  parameter int VREG_W  = 128,
  parameter bit BUF_OUT = 1'b1
) (
  input  logic                      clk_i,
  input  logic                      async_rst_i,
  input  logic                      stall_i,
  input  logic [REQ_CNT-1:0]        req_valid_i,
  output logic [REQ_CNT-1:0]        req_ready_o,
  input  logic [REQ_CNT-1:0]        req_lock_i,
  input  logic [REQ_CNT*5-1:0]      req_addr_i,
  input  logic [REQ_CNT*VREG_W-1:0] req_data_i,
  input  logic [REQ_CNT*VREG_W/8-1:0] req_be_i,
  output logic                      vreg_wr_en_o,
  output logic [4:0]                vreg_wr_addr_o,
  output logic [VREG_W-1:0]         vreg_wr_data_o,
  output logic [VREG_W/8-1:0]       vreg_wr_be_o,
  output logic [31:0]               pend_wr_o
);

  localparam int IDX_W = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1;
  localparam int BE_W  = VREG_W / 8;

  typedef enum logic {ARB, LOCKED} state_t;

  state_t             r_state, w_nxt_state;
  logic [IDX_W-1:0]   r_prio, w_nxt_prio;
  logic [IDX_W-1:0]   r_lidx, w_nxt_lidx;

  logic               w_found;
  logic [IDX_W-1:0]   w_win;
  logic [IDX_W-1:0]   w_sel;
  logic [IDX_W-1:0]   w_win_inc;
  logic [REQ_CNT-1:0] w_ready;
  logic               w_acc;
  logic [4:0]         w_addr;
  logic [VREG_W-1:0]  w_data;
  logic [BE_W-1:0]    w_be;

  // First valid requester scanning upward from r_prio with wrap-around.
  always_comb begin
    int k;
    w_found = 1'b0;
    w_win   = '0;
    k       = 0;
    for (int i = 0; i < REQ_CNT; i++) begin
      k = int'(r_prio) + i;
      if (k >= REQ_CNT) k = k - REQ_CNT;
      if (!w_found && req_valid_i[k]) begin
        w_found = 1'b1;
        w_win   = IDX_W'(k);
      end
    end
  end

  always_comb begin
    if (int'(w_win) + 1 >= REQ_CNT) w_win_inc = '0;
    else w_win_inc = w_win + IDX_W'(1);
  end

  always_comb begin
    w_ready = '0;
    if (!async_rst_i && !stall_i) begin
      if (r_state == LOCKED) w_ready[r_lidx] = 1'b1;
      else if (w_found) w_ready[w_win] = 1'b1;
    end
  end

  assign w_sel       = (r_state == LOCKED) ? r_lidx : w_win;
  assign w_acc       = |(req_valid_i & w_ready);
  assign req_ready_o = w_ready;

  assign w_addr = req_addr_i[w_sel*5 +: 5];
  assign w_data = req_data_i[w_sel*VREG_W +: VREG_W];
  assign w_be   = req_be_i[w_sel*BE_W +: BE_W];

  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      r_state <= ARB;
      r_prio  <= '0;
      r_lidx  <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_prio  <= w_nxt_prio;
      r_lidx  <= w_nxt_lidx;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_prio  = r_prio;
    w_nxt_lidx  = r_lidx;
    if (w_acc) begin
      unique case (r_state)
        ARB: begin
          w_nxt_prio = w_win_inc;
          if (req_lock_i[w_win]) begin
            w_nxt_state = LOCKED;
            w_nxt_lidx  = w_win;
          end
        end
        LOCKED: begin
          if (!req_lock_i[r_lidx]) w_nxt_state = ARB;
        end
        default: w_nxt_state = ARB;
      endcase
    end
  end

  generate
    if (BUF_OUT) begin : g_buf
      logic              r_en;
      logic [4:0]        r_addr;
      logic [VREG_W-1:0] r_data;
      logic [BE_W-1:0]   r_be;

      always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
          r_en   <= 1'b0;
          r_addr <= '0;
          r_data <= '0;
          r_be   <= '0;
        end else begin
          r_en <= w_acc;
          if (w_acc) begin
            r_addr <= w_addr;
            r_data <= w_data;
            r_be   <= w_be;
          end
        end
      end

      assign vreg_wr_en_o   = r_en;
      assign vreg_wr_addr_o = r_addr;
      assign vreg_wr_data_o = r_data;
      assign vreg_wr_be_o   = r_be;
      assign pend_wr_o      = r_en ? (32'd1 << r_addr) : 32'd0;
    end else begin : g_comb
      // Gate with reset so the port reads as zero while reset is held.
      assign vreg_wr_en_o   = w_acc;
      assign vreg_wr_addr_o = async_rst_i ? 5'd0 : w_addr;
      assign vreg_wr_data_o = async_rst_i ? '0 : w_data;
      assign vreg_wr_be_o   = async_rst_i ? '0 : w_be;
      assign pend_wr_o      = 32'd0;
    end
  endgenerate

endmodule

// File: tb/tb_vproc_vreg_wr_arbiter.sv
// Directed self-checking bench for vproc_vreg_wr_arbiter.
// Inputs change 1ns after posedge; checks happen mid-cycle.
module tb_vproc_vreg_wr_arbiter;

  localparam int RC = 5;
  localparam int VW = 128;
  localparam int BW = VW / 8;

  logic              clk;
  logic              rst;
  logic              stall;
  logic [RC-1:0]     valid;
  logic [RC-1:0]     ready;
  logic [RC-1:0]     lock;
  logic [RC*5-1:0]   addr;
  logic [RC*VW-1:0]  data;
  logic [RC*BW-1:0]  be;
  logic              en;
  logic [4:0]        waddr;
  logic [VW-1:0]     wdata;
  logic [BW-1:0]     wbe;
  logic [31:0]       pend;

  int n_cmp;
  int n_err;

  vproc_vreg_wr_arbiter #(
    .REQ_CNT(RC),
    .VREG_W (VW),
    .BUF_OUT(1'b1)
  ) dut (
    .clk_i         (clk),
    .async_rst_i   (rst),
    .stall_i       (stall),
    .req_valid_i   (valid),
    .req_ready_o   (ready),
    .req_lock_i    (lock),
    .req_addr_i    (addr),
    .req_data_i    (data),
    .req_be_i      (be),
    .vreg_wr_en_o  (en),
    .vreg_wr_addr_o(waddr),
    .vreg_wr_data_o(wdata),
    .vreg_wr_be_o  (wbe),
    .pend_wr_o     (pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    stall = 1'b0;
    valid = '0;
    lock  = '0;
    for (int i = 0; i < RC; i++) begin
      addr[i*5 +: 5]   = 5'(i + 1);
      data[i*VW +: VW] = {16{8'(8'hA0 + i)}};
      be[i*BW +: BW]   = '1;
    end

    repeat (2) @(posedge clk);
    #1;
    valid = 5'b11111;
    #4;
    chk("rst_ready", ready, 0);
    chk("rst_en", en, 0);
    chk("rst_pend", pend, 0);
    chk("rst_addr", waddr, 0);
    chk("rst_data", wdata, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Round-robin with all requesters valid
    for (int c = 0; c < 6; c++) begin
      #4;
      chk("rr_ready", ready, 128'(5'd1 << (c % 5)));
      if (c == 0) chk("rr_en0", en, 0);
      else begin
        chk("rr_en", en, 1);
        chk("rr_addr", waddr, 128'((c - 1) % 5 + 1));
      end
      tick();
    end
    valid = '0;
    #4;
    chk("rr_last_en", en, 1);
    chk("rr_last_addr", waddr, 1);
    chk("rr_idle_ready", ready, 0);
    tick();
    #4;
    chk("idle_en", en, 0);
    chk("idle_pend", pend, 0);
    chk("idle_addr_hold", waddr, 1);
    tick();

    // Burst lock on req1 against req3
    valid = 5'b01010;
    lock  = 5'b00010;
    for (int b = 0; b < 4; b++) begin
      if (b == 3) lock = '0;
      #4;
      chk("lock_ready", ready, 5'b00010);
      if (b > 0) begin
        chk("lock_en", en, 1);
        chk("lock_addr", waddr, 2);
      end
      tick();
    end
    #4;
    chk("lock_rel_ready", ready, 5'b01000);
    chk("lock_rel_addr", waddr, 2);
    tick();
    valid = '0;
    #4;
    chk("lock_r3_en", en, 1);
    chk("lock_r3_addr", waddr, 4);
    tick();

    // Pending bitmap, zero byte-enable beat
    addr[1*5 +: 5] = 5'd17;
    be[1*BW +: BW] = '0;
    valid = 5'b00010;
    #4;
    chk("pend_ready", ready, 5'b00010);
    tick();
    valid = '0;
    #4;
    chk("pend_en", en, 1);
    chk("pend_map", pend, 32'h0002_0000);
    chk("pend_be0", wbe, 0);
    chk("pend_addr", waddr, 17);
    tick();
    #4;
    chk("pend_clr", pend, 0);
    chk("pend_en_clr", en, 0);
    tick();

    // Locked owner req2 drops valid while req0 waits
    valid = 5'b00101;
    lock  = 5'b00100;
    #4;
    chk("gap_ready0", ready, 5'b00100);
    tick();
    valid = 5'b00001;
    #4;
    chk("gap_ready1", ready, 5'b00100);
    chk("gap_en1", en, 1);
    chk("gap_addr1", waddr, 3);
    tick();
    #4;
    chk("gap_ready2", ready, 5'b00100);
    chk("gap_en2", en, 0);
    tick();
    valid = 5'b00101;
    lock  = '0;
    #4;
    chk("gap_ready3", ready, 5'b00100);
    chk("gap_en3", en, 0);
    tick();
    valid = '0;
    #4;
    chk("gap_resume_en", en, 1);
    chk("gap_resume_addr", waddr, 3);
    tick();

    // Stall blocks grants and preserves priority
    stall = 1'b1;
    valid = 5'b10000;
    for (int s = 0; s < 3; s++) begin
      #4;
      chk("stall_ready", ready, 0);
      tick();
    end
    stall = 1'b0;
    #4;
    chk("unstall_ready", ready, 5'b10000);
    tick();
    valid = 5'b00001;
    #4;
    chk("r0_ready", ready, 5'b00001);
    chk("r4_en", en, 1);
    chk("r4_addr", waddr, 5);
    tick();
    stall = 1'b1;
    valid = 5'b11111;
    for (int s = 0; s < 2; s++) begin
      #4;
      chk("stall2_ready", ready, 0);
      tick();
    end
    stall = 1'b0;
    lock  = 5'b00010;
    #4;
    chk("prio_kept", ready, 5'b00010);
    tick();

    // Reset while locked with a held write
    #4;
    chk("pre_rst_en", en, 1);
    chk("pre_rst_ready", ready, 5'b00010);
    chk("pre_rst_pend", pend, 32'h0002_0000);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", ready, 0);
    chk("mid_rst_en", en, 0);
    chk("mid_rst_pend", pend, 0);
    chk("mid_rst_addr", waddr, 0);
    lock = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #4;
    chk("post_rst_ready", ready, 5'b00001);
    chk("post_rst_en", en, 0);
    tick();
    valid = '0;
    #4;
    chk("post_rst_wr_en", en, 1);
    chk("post_rst_addr", waddr, 1);
    chk("post_rst_data", wdata, {16{8'hA0}});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
